sdio_device_cmd_ctrl: RTL

SDIO_DEVICE_CMD_CTRL -- requirements
Module: sdio_device_cmd_ctrl

---
 rtl/sdio_device_cmd_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sdio_device_cmd_ctrl.sv
// SDIO device command controller: decodes PHY-captured commands, tracks the
// card state machine, builds zero-latency responses and drives CMD52 register access.
module sdio_device_cmd_ctrl #(
  parameter logic [23:0] OCR_VAL      = 24'hFF8000,
  parameter logic [2:0]  NUM_FUNCS    = 3'd1,
  parameter logic        MEM_PRESENT  = 1'b0,
  parameter logic [15:0] PWRUP_CYCLES = 16'd64
) (
  input  logic         sdio_clk,
  input  logic         rst_n,
  input  logic         cmd_stb,
  input  logic         cmd_crc_good_stb,
  input  logic [5:0]   cmd,
  input  logic [31:0]  cmd_arg,
  output logic [127:0] rsps,
  output logic [7:0]   rsps_len,
  output logic         rsps_fail,
  output logic [2:0]   card_state,
  output logic [15:0]  rca,
  output logic [16:0]  reg_addr,
  output logic [2:0]   reg_func,
  output logic [7:0]   reg_wdata,
  output logic         reg_wr_stb,
  input  logic [7:0]   reg_rdata
);

  typedef enum logic [2:0] {
    ST_INI   = 3'd0,
    ST_READY = 3'd1,
    ST_STBY  = 3'd2,
    ST_CMD   = 3'd3,
    ST_INA   = 3'd4
  } state_t;

  state_t      state, state_next, dec_state;
  logic [15:0] rca_next;
  logic        crc_err, crc_err_next;
  logic        illegal, illegal_next;
  logic [15:0] pwr_cnt;
  logic [15:0] lfsr;
  logic        ready;

  logic        act;
  logic        legal;
  logic        silent;
  logic        load_rca;
  logic        rca_match;
  logic        ocr_zero;
  logic        ocr_overlap;
  logic        func_err;
  logic        wr_req;

  // Gating with rst_n keeps write strobe and response suppression low in reset.
  assign act         = cmd_stb & rst_n;
  assign ready       = (pwr_cnt == PWRUP_CYCLES);
  assign rca_match   = (cmd_arg[31:16] == rca);
  assign ocr_zero    = (cmd_arg[23:0] == 24'd0);
  assign ocr_overlap = |(cmd_arg[23:0] & OCR_VAL);
  assign func_err    = (cmd_arg[30:28] > NUM_FUNCS);
  assign wr_req      = cmd_arg[31] & ~func_err;

  assign card_state  = state;
  assign reg_addr    = cmd_arg[25:9];
  assign reg_func    = cmd_arg[30:28];
  assign reg_wdata   = cmd_arg[7:0];

  // Power-up counter and free-running LFSR
  always_ff @(posedge sdio_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_cnt <= 16'd0;
      lfsr    <= 16'hACE1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!ready) pwr_cnt <= pwr_cnt + 16'd1;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // State register
  always_ff @(posedge sdio_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INI;
      rca     <= 16'd0;
      crc_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      rca     <= rca_next;
      crc_err <= crc_err_next;
      illegal <= illegal_next;
    end
  end

  // Command decode: legality, silence and target state in the current state
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    legal     = 1'b0;
    silent    = 1'b0;
    load_rca  = 1'b0;
    dec_state = state;
    case (cmd)
      6'd0: begin
        legal     = (state != ST_INA);
        silent    = 1'b1;
        dec_state = ST_INI;
      end
      6'd5: begin
        legal = (state == ST_INI) || (state == ST_READY);
        if (ocr_zero)         dec_state = state;
        else if (ocr_overlap) dec_state = ready ? ST_READY : state;
        else                  dec_state = ST_INA;
      end
      6'd3: begin
        legal     = (state == ST_READY) || (state == ST_STBY);
        load_rca  = 1'b1;
        dec_state = ST_STBY;
      end
      6'd7: begin
        legal     = (state == ST_STBY) || (state == ST_CMD);
        silent    = ~rca_match;
        dec_state = rca_match ? ST_CMD : ST_STBY;
      end
      6'd15: begin
        legal     = rca_match &&
                    ((state == ST_READY) || (state == ST_STBY) || (state == ST_CMD));
        silent    = 1'b1;
        dec_state = ST_INA;
      end
      6'd52: begin
        legal = (state == ST_CMD);
      end
      default: ;
    endcase
  end

  // Next-state logic; INA freezes everything until reset
  always_comb begin
    state_next   = state;
    rca_next     = rca;
    crc_err_next = crc_err;
    illegal_next = illegal;
    if (act && state != ST_INA) begin
      if (!cmd_crc_good_stb) begin
        crc_err_next = 1'b1;
      end else if (!legal) begin
        illegal_next = 1'b1;
      end else begin
        state_next = dec_state;
        if (cmd == 6'd0)   rca_next = 16'd0;
        else if (load_rca) rca_next = lfsr;
        // Flags are reported by any transmitted response, then cleared.
        if (cmd == 6'd0 || !silent) begin
          crc_err_next = 1'b0;
          illegal_next = 1'b0;
        end
      end
    end
  end

  // Response and register-strobe outputs
  logic [5:0]  resp_idx;
  logic [31:0] payload;
  logic [7:0]  r5_data;
  logic        r4_c;

  always_comb begin
    resp_idx = cmd;
    payload  = 32'd0;
    r4_c     = (!ocr_zero && !ocr_overlap) ? 1'b0 : ready;
    if (func_err)         r5_data = 8'h00;
    else if (cmd_arg[31]) r5_data = cmd_arg[27] ? cmd_arg[7:0] : reg_rdata;
    else                  r5_data = reg_rdata;
    case (cmd)
      6'd5: begin
        resp_idx = 6'h3F;
        payload  = {r4_c, NUM_FUNCS, MEM_PRESENT, 3'b000, OCR_VAL};
      end
      6'd3:  payload = {lfsr, crc_err, illegal, 1'b0, 4'd3, 9'd0};
      6'd7: begin
        payload[23]   = crc_err;
        payload[22]   = illegal;
        payload[12:9] = (state == ST_CMD) ? 4'd4 : 4'd3;
      end
      6'd52: payload = {16'd0, crc_err, illegal, 2'b01, 1'b0, 1'b0, func_err, 1'b0, r5_data};
      default: ;
    endcase
    rsps       = {resp_idx, payload, 90'd0};
    rsps_len   = 8'd38;
    rsps_fail  = act & (~cmd_crc_good_stb | ~legal | silent | (state == ST_INA));
    reg_wr_stb = act & cmd_crc_good_stb & legal & (cmd == 6'd52) & wr_req;
  end

endmodule
